// File: rtl/spatialacc_drain.sv
// Result drain for the 4x4 spatial accumulator: snapshots all lanes on start, clears the
// accumulator, then streams the snapshot lane by lane over valid/ready.
module spatialacc_drain #(
  parameter int unsigned N       = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  acc_in [0:N-1],
  output logic               acc_clear,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               done,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    snap_q [0:N-1];
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 out_last_q, out_last_d;
  logic                 acc_clear_q, acc_clear_d;
  logic                 done_q, done_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                 capture;
  logic                 at_last;
  logic [IDX_W-1:0]     idx_nxt;

  assign capture = (state_q == StIdle) && start;
  assign at_last = (idx_q == IDX_W'(N - 1));
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    acc_clear_d = 1'b0;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // First word comes straight from the inputs since the snapshot loads on this edge.
          state_d     = StSend;
          idx_d       = '0;
          out_data_d  = acc_in[0];
          out_last_d  = (N == 1);
          acc_clear_d = 1'b1;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (at_last) begin
            state_d     = StIdle;
            idx_d       = '0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = snap_q[idx_nxt];
            out_last_d = (idx_nxt == IDX_W'(N - 1));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      acc_clear_q <= acc_clear_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (rst) begin
        snap_q[i] <= '0;
      end else if (capture) begin
        snap_q[i] <= acc_in[i];
      end
    end
  end

  assign acc_clear = acc_clear_q;
  assign busy      = (state_q == StSend);
  assign out_valid = (state_q == StSend);
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule
